// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, run/pause/lap/clear FSM and a
// hundredths timebase that feeds a binary count to the display converter.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int MAX_COUNT       = 9999,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [15:0] disp_val,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int              DIV        = CLK_HZ / TICK_HZ;
  localparam int              PW         = $clog2(DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam int              DW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]   DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     COUNT_MAX  = 16'(MAX_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_LAP    = 2'd3
  } state_t;

  // bit 0 start/stop, bit 1 lap, bit 2 clear
  logic [2:0] btn_raw_s;
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] press_s;

  assign btn_raw_s = {btn_clear, btn_lap, btn_start_stop};

  // Two-stage synchroniser for the asynchronous buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DW-1:0] cnt_r;
    logic          level_r;
    logic          press_r;

    // Level follows the synced input only after a full run of differing samples
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_r   <= {DW{1'b0}};
        level_r <= 1'b0;
        press_r <= 1'b0;
      end else if (sync2_r[i] != level_r) begin
        if (cnt_r == DB_LAST) begin
          cnt_r   <= {DW{1'b0}};
          level_r <= sync2_r[i];
          press_r <= sync2_r[i];
        end else begin
          cnt_r   <= cnt_r + {{(DW-1){1'b0}}, 1'b1};
          press_r <= 1'b0;
        end
      end else begin
        cnt_r   <= {DW{1'b0}};
        press_r <= 1'b0;
      end
    end

    assign press_s[i] = press_r;
  end

  state_t        state_r, state_nx;
  logic [PW-1:0] presc_r, presc_nx;
  logic [15:0]   count_r, count_nx;
  logic [15:0]   lap_r, lap_nx;
  logic          ovf_r, ovf_nx;
  logic [15:0]   disp_r, disp_nx;
  logic          running_r, running_nx;
  logic          lap_act_r, lap_act_nx;
  logic          clear_go_s, lap_go_s, counting_s, tick_s;

  // Next state with pulse priority clear > start/stop > lap, illegal pulses dropped
  always_comb begin
    state_nx   = state_r;
    clear_go_s = 1'b0;
    lap_go_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_s[0]) state_nx = ST_RUN;
        else            state_nx = ST_IDLE;
      end
      ST_RUN: begin
        if (press_s[0]) begin
          state_nx = ST_PAUSED;
        end else if (press_s[1]) begin
          state_nx = ST_LAP;
          lap_go_s = 1'b1;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_LAP: begin
        if (press_s[0])      state_nx = ST_PAUSED;
        else if (press_s[1]) state_nx = ST_RUN;
        else                 state_nx = ST_LAP;
      end
      ST_PAUSED: begin
        if (press_s[2]) begin
          state_nx   = ST_IDLE;
          clear_go_s = 1'b1;
        end else if (press_s[0]) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_PAUSED;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Timebase, count, lap capture and the registered output values
  always_comb begin
    counting_s = (state_r == ST_RUN) || (state_r == ST_LAP);
    tick_s     = counting_s && (presc_r == PRESC_LAST);
    presc_nx   = presc_r;
    count_nx   = count_r;
    ovf_nx     = ovf_r;
    lap_nx     = lap_r;
    if (clear_go_s) begin
      presc_nx = {PW{1'b0}};
    end else if (counting_s) begin
      if (tick_s) presc_nx = {PW{1'b0}};
      else        presc_nx = presc_r + {{(PW-1){1'b0}}, 1'b1};
    end else if (state_r == ST_IDLE) begin
      presc_nx = {PW{1'b0}};
    end else begin
      presc_nx = presc_r;
    end
    if (clear_go_s) begin
      count_nx = 16'd0;
      ovf_nx   = 1'b0;
    end else if (tick_s) begin
      if (count_r == COUNT_MAX) begin
        count_nx = 16'd0;
        ovf_nx   = 1'b1;
      end else begin
        count_nx = count_r + 16'd1;
        ovf_nx   = ovf_r;
      end
    end else begin
      count_nx = count_r;
      ovf_nx   = ovf_r;
    end
    // Lap takes the pre-increment value even when a tick lands on the same edge
    if (lap_go_s) lap_nx = count_r;
    else          lap_nx = lap_r;
    disp_nx    = (state_nx == ST_LAP) ? lap_nx : count_nx;
    running_nx = (state_nx == ST_RUN) || (state_nx == ST_LAP);
    lap_act_nx = (state_nx == ST_LAP);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      presc_r   <= {PW{1'b0}};
      count_r   <= 16'd0;
      lap_r     <= 16'd0;
      ovf_r     <= 1'b0;
      disp_r    <= 16'd0;
      running_r <= 1'b0;
      lap_act_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      presc_r   <= presc_nx;
      count_r   <= count_nx;
      lap_r     <= lap_nx;
      ovf_r     <= ovf_nx;
      disp_r    <= disp_nx;
      running_r <= running_nx;
      lap_act_r <= lap_act_nx;
    end
  end

  assign disp_val   = disp_r;
  assign running    = running_r;
  assign lap_active = lap_act_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: two DUTs (full range and wrap at 15)
// share the buttons and are checked every cycle against an arithmetic model.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DEB     = 4;
  localparam int MAX_A   = 9999;
  localparam int MAX_B   = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        b_ss = 1'b0, b_lap = 1'b0, b_clr = 1'b0;
  logic [15:0] disp_a, disp_b;
  logic        run_a, run_b, lapact_a, lapact_b, ovf_a, ovf_b;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_COUNT(MAX_A), .DEBOUNCE_CYCLES(DEB)) dut_a (
    .clk(clk), .reset(reset), .btn_start_stop(b_ss), .btn_lap(b_lap), .btn_clear(b_clr),
    .disp_val(disp_a), .running(run_a), .lap_active(lapact_a), .overflow(ovf_a));

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_COUNT(MAX_B), .DEBOUNCE_CYCLES(DEB)) dut_b (
    .clk(clk), .reset(reset), .btn_start_stop(b_ss), .btn_lap(b_lap), .btn_clear(b_clr),
    .disp_val(disp_b), .running(run_b), .lap_active(lapact_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] da;
    logic [15:0] db;
    logic        run;
    logic        lapa;
    logic        oa;
    logic        ob;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: mode, total counting edges since clear, debounced levels
  typedef enum {STOPPED, TIMING, HELD, SPLIT} mode_t;
  mode_t       m_mode;
  int          run_edges;
  int          lap_a, lap_b;
  bit [2:0]    level_m, pulse_m;
  bit [31:0]   hist_m [3];

  function automatic int cnt_of(input int maxv);
    return (run_edges / DIV) % (maxv + 1);
  endfunction

  function automatic exp_t exp_now();
    exp_t e;
    e.da   = 16'((m_mode == SPLIT) ? lap_a : cnt_of(MAX_A));
    e.db   = 16'((m_mode == SPLIT) ? lap_b : cnt_of(MAX_B));
    e.run  = (m_mode == TIMING) || (m_mode == SPLIT);
    e.lapa = (m_mode == SPLIT);
    e.oa   = (run_edges / DIV) > MAX_A;
    e.ob   = (run_edges / DIV) > MAX_B;
    return e;
  endfunction

  task automatic model_reset();
    m_mode    = STOPPED;
    run_edges = 0;
    lap_a     = 0;
    lap_b     = 0;
    level_m   = 3'b000;
    pulse_m   = 3'b000;
    for (int i = 0; i < 3; i++) hist_m[i] = 32'd0;
  endtask

  task automatic model_step(input bit [2:0] raw);
    bit ss, lp, cl, agree;
    int ca, cb;
    ss = pulse_m[0]; lp = pulse_m[1]; cl = pulse_m[2];
    ca = cnt_of(MAX_A);
    cb = cnt_of(MAX_B);
    if (m_mode == TIMING || m_mode == SPLIT) run_edges++;
    case (m_mode)
      STOPPED: if (ss) m_mode = TIMING;
      TIMING:  if (ss) m_mode = HELD;
               else if (lp) begin m_mode = SPLIT; lap_a = ca; lap_b = cb; end
      SPLIT:   if (ss) m_mode = HELD; else if (lp) m_mode = TIMING;
      HELD:    if (cl) begin m_mode = STOPPED; run_edges = 0; end
               else if (ss) m_mode = TIMING;
      default: m_mode = STOPPED;
    endcase
    // a press is accepted once DEB synced samples (raw delayed by 2) all differ from the level
    for (int i = 0; i < 3; i++) begin
      hist_m[i]  = {hist_m[i][30:0], raw[i]};
      pulse_m[i] = 1'b0;
      agree      = 1'b1;
      for (int j = 2; j < DEB + 2; j++) if (hist_m[i][j] == level_m[i]) agree = 1'b0;
      if (agree) begin
        level_m[i] = ~level_m[i];
        pulse_m[i] = level_m[i];
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one expected entry per clock, compared half a cycle later
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("disp_a",     int'(disp_a),   int'(e.da));
      chk("disp_b",     int'(disp_b),   int'(e.db));
      chk("running_a",  int'(run_a),    int'(e.run));
      chk("running_b",  int'(run_b),    int'(e.run));
      chk("lap_a",      int'(lapact_a), int'(e.lapa));
      chk("lap_b",      int'(lapact_b), int'(e.lapa));
      chk("overflow_a", int'(ovf_a),    int'(e.oa));
      chk("overflow_b", int'(ovf_b),    int'(e.ob));
    end
  end

  // raw = {clear, lap, start_stop}; inputs change on the falling edge
  task automatic cycle(input bit [2:0] raw);
    {b_clr, b_lap, b_ss} = raw;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step(raw);
    sb_q.push_back(exp_now());
    @(negedge clk);
  endtask

  task automatic hold(input bit [2:0] raw, input int n);
    repeat (n) cycle(raw);
  endtask

  task automatic press(input bit [2:0] raw, input int n);
    hold(raw, n);
    hold(3'b000, 10);
  endtask

  task automatic wait_count(input int target);
    int k = 0;
    while (cnt_of(MAX_A) < target && k < 2000) begin
      cycle(3'b000);
      k++;
    end
    n_vec++;
    if (k >= 2000) begin
      n_bad++;
      $display("FAIL wait_count: reached %0d required %0d", cnt_of(MAX_A), target);
    end
  endtask

  // Reset lands just after an edge so the zeros are seen before the next edge
  task automatic async_reset();
    {b_clr, b_lap, b_ss} = 3'b000;
    @(posedge clk);
    model_step(3'b000);
    #1 reset = 1'b0;
    model_reset();
    sb_q.push_back(exp_now());
    @(negedge clk);
    hold(3'b000, 3);
    reset = 1'b1;
    hold(3'b000, 20);
  endtask

  initial begin
    model_reset();
    hold(3'b000, 3);
    reset = 1'b1;
    hold(3'b000, 5);

    // start, run ~100 cycles
    press(3'b001, 10);
    hold(3'b000, 100);

    // pause, then bounce start/stop before a steady press resumes
    press(3'b001, 6);
    hold(3'b001, 1); hold(3'b000, 1); hold(3'b001, 1); hold(3'b000, 1);
    press(3'b001, 10);

    // lap freeze and release
    wait_count(25);
    press(3'b010, 6);
    hold(3'b000, 50);
    press(3'b010, 6);
    hold(3'b000, 30);

    // narrow instance has wrapped by now; pause and clear
    press(3'b001, 6);
    press(3'b100, 6);
    hold(3'b000, 20);

    // clear and start/stop together while paused: clear wins
    press(3'b001, 6);
    hold(3'b000, 30);
    press(3'b001, 6);
    press(3'b101, 6);
    hold(3'b000, 20);

    // clear ignored in RUN, then reset mid-run
    press(3'b001, 6);
    press(3'b100, 6);
    wait_count(40);
    async_reset();

    // random button activity with bounce
    for (int it = 0; it < 250; it++) begin
      hold(3'($urandom_range(0, 7)), int'($urandom_range(1, 9)));
      if (it == 180) async_reset();
    end
    hold(3'b000, 20);
    @(negedge clk);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
